// File: rtl/xaddrgen_n_if.sv
// xaddrgen_n_if: bundle of the configuration, control and address signals of xaddrgen_n.
//
// Parameters mirror the generator: MEM_ADDR_W (address / count width), PERIOD_W (period,
// duty and delay width), NUM_LEVELS (loop depth).
//
// Signals (direction as seen by the generator, i.e. the slave modport):
//   run_i         in   start pulse, samples the configuration below
//   pause_i       in   stall request (only honoured when XADDRGEN_N_PAUSE_EN is defined)
//   iterations_i  in   per-level iteration counts, level k at [k*MEM_ADDR_W +: MEM_ADDR_W]
//   shift_i       in   per-level signed base shifts, same packing
//   period_i      in   level-0 period length
//   duty_i        in   enabled cycles per period
//   delay_i       in   cycles between run_i and the first RUN cycle
//   start_i       in   start address
//   incr_i        in   signed level-0 address increment
//   addr_o        out  address
//   mem_en_o      out  address valid
//   done_o        out  idle / complete
interface xaddrgen_n_if #(
   parameter int unsigned MEM_ADDR_W = 10,
   parameter int unsigned PERIOD_W   = 10,
   parameter int unsigned NUM_LEVELS = 3
) ();
   logic                             run_i;
   logic                             pause_i;
   logic [NUM_LEVELS*MEM_ADDR_W-1:0] iterations_i;
   logic [NUM_LEVELS*MEM_ADDR_W-1:0] shift_i;
   logic [PERIOD_W-1:0]              period_i;
   logic [PERIOD_W-1:0]              duty_i;
   logic [PERIOD_W-1:0]              delay_i;
   logic [MEM_ADDR_W-1:0]            start_i;
   logic [MEM_ADDR_W-1:0]            incr_i;
   logic [MEM_ADDR_W-1:0]            addr_o;
   logic                             mem_en_o;
   logic                             done_o;

   modport master (
      output run_i, pause_i, iterations_i, shift_i, period_i, duty_i, delay_i, start_i, incr_i,
      input  addr_o, mem_en_o, done_o
   );

   modport slave (
      input  run_i, pause_i, iterations_i, shift_i, period_i, duty_i, delay_i, start_i, incr_i,
      output addr_o, mem_en_o, done_o
   );
endinterface

// File: rtl/xaddrgen_n.sv
// xaddrgen_n: nested-loop memory address generator.
//
// A level-0 period of period_i cycles emits duty_i enabled addresses b[0] + p*incr_i. Each
// finished period moves b[0] by shift[0]; when level k has run its iteration count, b[k+1]
// moves by shift[k+1] and every lower base restarts from it. An optional start delay precedes
// the first period. All address arithmetic wraps modulo 2^MEM_ADDR_W.
//
// Optional feature: define XADDRGEN_N_PAUSE_EN to honour bus.pause_i (freezes the sequence,
// masks mem_en_o, holds addr_o). Without it pause_i is accepted and ignored.
//
// Ports:
//   clk_i  in   clock
//   rst_i  in   asynchronous active-high reset
//   bus    xaddrgen_n_if.slave: run/pause/configuration in, addr_o/mem_en_o/done_o out
module xaddrgen_n #(
   parameter int unsigned MEM_ADDR_W = 10,
   parameter int unsigned PERIOD_W   = 10,
   parameter int unsigned NUM_LEVELS = 3
) (
   input logic         clk_i,
   input logic         rst_i,
   xaddrgen_n_if.slave bus
);
   localparam int unsigned AW = MEM_ADDR_W;
   localparam int unsigned PW = PERIOD_W;
   localparam int unsigned LW = 3;  // counts completed levels, 0..NUM_LEVELS (max 4)

   typedef enum logic [1:0] {StIdle, StDelay, StRun} state_e;

   state_e        st_q, st_d;
   logic [PW-1:0] period_q, period_d;
   logic [PW-1:0] duty_q, duty_d;
   logic [PW-1:0] dly_q, dly_d;
   logic [PW-1:0] p_q, p_d;
   logic [AW-1:0] incr_q, incr_d;
   logic [AW-1:0] off_q, off_d;   // running p*incr, avoids a multiplier
   logic [AW-1:0] addr_q, addr_d;
   logic          mem_en_q, mem_en_d;
   logic          done_q;
   logic [AW-1:0] iter_q  [NUM_LEVELS];
   logic [AW-1:0] iter_d  [NUM_LEVELS];
   logic [AW-1:0] shift_q [NUM_LEVELS];
   logic [AW-1:0] shift_d [NUM_LEVELS];
   logic [AW-1:0] cnt_q   [NUM_LEVELS];
   logic [AW-1:0] cnt_d   [NUM_LEVELS];
   logic [AW-1:0] b_q     [NUM_LEVELS];
   logic [AW-1:0] b_d     [NUM_LEVELS];

   logic [NUM_LEVELS-1:0] wrap;
   logic [LW-1:0]         n_done;
   logic [AW-1:0]         nb;
   logic [PW-1:0]         duty_clamp;
   logic                  pause_act;

`ifdef XADDRGEN_N_PAUSE_EN
   // run_i wins over pause so a restart is never swallowed.
   assign pause_act = bus.pause_i & ~bus.run_i;
`else
   logic unused_pause;
   assign unused_pause = bus.pause_i;
   assign pause_act    = 1'b0;
`endif

   assign duty_clamp = (bus.duty_i > bus.period_i) ? bus.period_i : bus.duty_i;

   // wrap[k]: level k is on its last pass (a count of 0 behaves as 1).
   // n_done: number of consecutive levels, from level 0 up, that finish with this period.
   always_comb begin
      logic chain;
      chain  = 1'b1;
      n_done = '0;
      for (int k = 0; k < NUM_LEVELS; k++) begin
         wrap[k] = (iter_q[k] == '0) || (cnt_q[k] == iter_q[k] - AW'(1));
         chain   = chain & wrap[k];
         if (chain) n_done = LW'(k + 1);
      end
   end

   always_comb begin
      st_d     = st_q;
      period_d = period_q;
      duty_d   = duty_q;
      incr_d   = incr_q;
      dly_d    = dly_q;
      p_d      = p_q;
      off_d    = off_q;
      nb       = '0;
      for (int k = 0; k < NUM_LEVELS; k++) begin
         iter_d[k]  = iter_q[k];
         shift_d[k] = shift_q[k];
         cnt_d[k]   = cnt_q[k];
         b_d[k]     = b_q[k];
      end

      if (bus.run_i) begin
         period_d = bus.period_i;
         duty_d   = duty_clamp;
         incr_d   = bus.incr_i;
         p_d      = '0;
         off_d    = '0;
         dly_d    = '0;
         for (int k = 0; k < NUM_LEVELS; k++) begin
            iter_d[k]  = bus.iterations_i[k*AW +: AW];
            shift_d[k] = bus.shift_i[k*AW +: AW];
            cnt_d[k]   = '0;
            b_d[k]     = bus.start_i;
         end
         if (bus.delay_i != '0) begin
            st_d  = StDelay;
            dly_d = bus.delay_i - PW'(1);
         end else if (bus.period_i == '0) begin
            st_d = StIdle;  // nothing to emit
         end else begin
            st_d = StRun;
         end
      end else if (!pause_act) begin
         unique case (st_q)
            StDelay: begin
               if (dly_q == '0) st_d = (period_q == '0) ? StIdle : StRun;
               else dly_d = dly_q - PW'(1);
            end
            StRun: begin
               if (p_q != period_q - PW'(1)) begin
                  p_d   = p_q + PW'(1);
                  off_d = off_q + incr_q;
               end else begin
                  p_d   = '0;
                  off_d = '0;
                  if (n_done == LW'(NUM_LEVELS)) begin
                     st_d = StIdle;
                  end else begin
                     // Level n_done steps its base; all levels below restart from it.
                     for (int k = 0; k < NUM_LEVELS; k++) begin
                        if (LW'(k) == n_done) nb = b_q[k] + shift_q[k];
                     end
                     for (int k = 0; k < NUM_LEVELS; k++) begin
                        if (LW'(k) < n_done) begin
                           cnt_d[k] = '0;
                           b_d[k]   = nb;
                        end else if (LW'(k) == n_done) begin
                           cnt_d[k] = cnt_q[k] + AW'(1);
                           b_d[k]   = nb;
                        end
                     end
                  end
               end
            end
            default: ;
         endcase
      end

      mem_en_d = (st_d == StRun) && (p_d < duty_d) && !pause_act;
      addr_d   = mem_en_d ? (b_d[0] + off_d) : addr_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         st_q     <= StIdle;
         period_q <= '0;
         duty_q   <= '0;
         incr_q   <= '0;
         dly_q    <= '0;
         p_q      <= '0;
         off_q    <= '0;
         addr_q   <= '0;
         mem_en_q <= 1'b0;
         done_q   <= 1'b1;
         for (int k = 0; k < NUM_LEVELS; k++) begin
            iter_q[k]  <= '0;
            shift_q[k] <= '0;
            cnt_q[k]   <= '0;
            b_q[k]     <= '0;
         end
      end else begin
         st_q     <= st_d;
         period_q <= period_d;
         duty_q   <= duty_d;
         incr_q   <= incr_d;
         dly_q    <= dly_d;
         p_q      <= p_d;
         off_q    <= off_d;
         addr_q   <= addr_d;
         mem_en_q <= mem_en_d;
         done_q   <= (st_d == StIdle);
         for (int k = 0; k < NUM_LEVELS; k++) begin
            iter_q[k]  <= iter_d[k];
            shift_q[k] <= shift_d[k];
            cnt_q[k]   <= cnt_d[k];
            b_q[k]     <= b_d[k];
         end
      end
   end

   assign bus.addr_o   = addr_q;
   assign bus.mem_en_o = mem_en_q;
   assign bus.done_o   = done_q;
endmodule

// File: doc/xaddrgen_n.md
XADDRGEN_N -- requirements
Module: xaddrgen_n

Interface
REQ-001 SHALL have parameter MEM_ADDR_W, default 10, address and iteration-count width.
REQ-002 SHALL have parameter PERIOD_W, default 10, width of period, duty and delay.
REQ-003 SHALL have parameter NUM_LEVELS, default 3, nested loop depth, legal range 1..4; level 0 is innermost.
REQ-004 SHALL have ports: clk_i  in  1  clock, single domain; rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: run_i  in  1  start pulse; pause_i  in  1  stall request.
REQ-006 SHALL have ports: iterations_i  in  NUM_LEVELS*MEM_ADDR_W  per-level iteration counts; shift_i  in  NUM_LEVELS*MEM_ADDR_W  signed per-level shifts; level k occupies bits [k*MEM_ADDR_W +: MEM_ADDR_W].
REQ-007 SHALL have ports: period_i, duty_i, delay_i  in  PERIOD_W each  level-0 period, enabled cycles per period, start delay; start_i  in  MEM_ADDR_W  start address; incr_i  in  MEM_ADDR_W  signed level-0 increment.
REQ-008 SHALL have ports: addr_o  out  MEM_ADDR_W  address; mem_en_o  out  1  address valid; done_o  out  1  idle/complete.

Function
REQ-009 SHALL register all configuration inputs on the cycle run_i is high; inputs are ignored at all other times.
REQ-010 SHALL implement states IDLE, DELAY, RUN: IDLE->DELAY on run_i if delay_i>0, IDLE->RUN on run_i if delay_i==0, DELAY->RUN after delay_i cycles, RUN->IDLE after the last period of the outermost level.
REQ-011 SHALL keep per-level base registers b[k], all loaded with start_i on run_i, and a period counter p.
REQ-012 SHALL, in RUN, drive mem_en_o=1 and addr_o=b[0]+p*incr_i when p<duty_i; it SHALL drive mem_en_o=0 and hold addr_o otherwise. The product SHALL be computed incrementally, not with a multiplier.
REQ-013 SHALL, at the end of each level-0 period, set b[0]+=shift[0]. When level k completes iterations[k] passes, it SHALL set b[k+1]+=shift[k+1] and reload all b[j], j<=k, with the new b[k+1].
REQ-014 SHALL start the first address on the cycle after run_i when delay_i==0, otherwise delay_i cycles later.
REQ-015 SHALL treat an iterations field of 0 as 1, so the level is bypassed.
REQ-016 SHALL, when period_i==0 or duty_i==0, complete with no mem_en_o pulses; done_o SHALL be 1 at most period_i*prod(iter)+delay_i+1 cycles after run_i.
REQ-017 SHALL clamp duty_i greater than period_i to period_i.
REQ-018 SHALL wrap all address arithmetic modulo 2^MEM_ADDR_W, with no saturation.
REQ-019 SHALL drive done_o=1 exactly in IDLE; done_o SHALL fall on the cycle after run_i and rise on the cycle after the final RUN cycle.
REQ-020 SHALL, on run_i while in DELAY or RUN, abort and restart with the new configuration; run_i has priority over completion in the same cycle.

Reset
REQ-021 SHALL force state IDLE, addr_o=0, mem_en_o=0, done_o=1, and all counters and bases to 0 asynchronously when rst_i is high, including mid-operation.
REQ-022 SHALL ignore run_i while rst_i is high; the first run_i after reset release SHALL behave as from idle.

Configuration
REQ-023 SHALL honour pause_i only when macro XADDRGEN_N_PAUSE_EN is defined: pause_i=1 freezes state, p, delay counter and all bases, forces mem_en_o=0 and holds addr_o. On release, the sequence SHALL resume at the frozen point with no address lost or repeated.
REQ-024 SHALL, without XADDRGEN_N_PAUSE_EN, keep port pause_i present but ignore it, with no pause logic synthesised.

Verification
REQ-025 NUM_LEVELS=2, start=100, incr=1, period=3, duty=2, iter0=2, shift0=5, iter1=2, shift1=20, delay=0 -> enabled addresses 100,101,105,106,120,121,125,126 (one gap cycle after each pair); done_o rises 13 cycles after run_i.
REQ-026 Same config with delay=4 -> first mem_en_o 5 cycles after run_i; the sequence is otherwise identical.
REQ-027 MEM_ADDR_W=10, start=1020, incr=2, period=duty=4, single pass -> addresses 1020,1022,0,2.
REQ-028 iter1=0, rest as in REQ-025 -> addresses 100,101,105,106 only; done_o follows the gap cycle.
REQ-029 rst_i pulsed mid-RUN, then run_i with the REQ-025 config -> outputs reach reset values immediately; the full REQ-025 sequence repeats exactly.
REQ-030 With XADDRGEN_N_PAUSE_EN, pause_i held 3 cycles after address 105 -> mem_en_o=0 for 3 cycles, addr_o held at 105, then 106 continues; done_o is delayed by 3 cycles.
